branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL expose these ports; clock and reset come first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID-stage instruction valid.
- id_is_beq / id_is_bne  in  1 each  ID-stage decode flags.
- id_rs / id_rt  in  5 each  branch source registers.
- ex_regwrite / ex_memread  in  1 each  EX-stage control.
- ex_rd  in  5  EX-stage destination register.
- mem_regwrite / mem_memread  in  1 each  MEM-stage control.
- mem_rd  in  5  MEM-stage destination register.
- is_equal  in  1  result of the 32-bit ID-stage equality comparator.
- fwd_a_sel / fwd_b_sel  out  1 each  comparator operand select: 0 = regfile, 1 = EX/MEM ALU result.
- stall  out  1  freeze PC and IF/ID.
- pc_src  out  1  select branch target.
- if_flush  out  1  squash IF/ID.
- taken_cnt  out  16  count of taken branches.
- stall_cnt  out  16  count of branch stall cycles.
REQ-002 There is one clock, and reset is asynchronous and active-low.

Function
REQ-003 The branch signal br SHALL be id_valid & (id_is_beq | id_is_bne); if both flags are set, the branch SHALL be treated as beq.
REQ-004 A register match SHALL require a nonzero register number; register $0 SHALL never cause a hazard or a forward.
REQ-005 The required stall count N SHALL be the maximum over rs and rt of:
- 2 for an EX load match (ex_memread & ex_regwrite & ex_rd==reg);
- 1 for an EX ALU match;
- 1 for a MEM load match;
- 0 otherwise.
REQ-006 fwd_x_sel SHALL be 1 when mem_regwrite & !mem_memread & mem_rd==reg (reg nonzero); otherwise it SHALL be 0. It SHALL be evaluated combinationally in every state.
REQ-007 The FSM SHALL have three states: IDLE, STALL, RESOLVE.
REQ-008 In IDLE with br and N==0, the branch SHALL resolve in the same cycle: taken = is_equal for beq, !is_equal for bne, pc_src = if_flush = taken, and the state SHALL stay IDLE.
REQ-009 In IDLE with br and N>0, stall SHALL assert combinationally, a 2-bit counter SHALL load N-1, and the next state SHALL be STALL if N==2, otherwise RESOLVE.
REQ-010 In STALL, stall SHALL be 1 and the counter SHALL decrement; when it reaches 0 the next state SHALL be RESOLVE.
REQ-011 In RESOLVE, the block SHALL re-evaluate N:
- If N>0, it SHALL stall and re-enter per REQ-009 (this is a safety path only).
- Otherwise it SHALL resolve per REQ-008 and go to IDLE.
REQ-012 pc_src and if_flush SHALL never assert while stall is 1, and SHALL be single-cycle per branch.
REQ-013 If id_valid deasserts in STALL or RESOLVE, the block SHALL go to IDLE next cycle with no resolution; stall SHALL drop in that same cycle.
REQ-014 taken_cnt SHALL increment on each resolved taken branch, saturating at 0xFFFF.
REQ-015 stall_cnt SHALL increment on each cycle with stall=1, saturating at 0xFFFF.
REQ-016 Latency SHALL be 0 cycles when there is no hazard, 1 cycle for an ALU or MEM-load hazard, and 2 cycles for an EX-load hazard.

Reset
REQ-017 When rst_n=0, the block SHALL immediately force state=IDLE, counter=0, taken_cnt=0 and stall_cnt=0. All outputs SHALL read 0 given br=0.
REQ-018 A reset asserted mid-STALL SHALL abort the branch; after release, the block SHALL re-evaluate from IDLE.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- No hazard: beq, rs=3, rt=4, is_equal=1 -> same cycle pc_src=1, if_flush=1, stall=0, taken_cnt=1.
- EX ALU hazard: ex_regwrite=1, ex_rd=3; next cycle mem_rd=3, mem_regwrite=1; bne, is_equal=0 -> stall 1 cycle, then fwd_a_sel=1, pc_src=1, stall_cnt=1.
- EX load hazard: ex_memread=1, ex_rd=4 (rt) -> stall 2 cycles, resolve in cycle 3, stall_cnt=2.
- $0 and priority: rs=0 with ex_rd=0, ex_regwrite=1 -> no stall; beq with bne both set and is_equal=1 -> taken.
- Abort and reset: id_valid drops during STALL -> IDLE with no pc_src; rst_n low mid-STALL -> stall=0 immediately and counters=0.
- Saturation: preload 0xFFFF taken branches -> taken_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the ID stage: hazard stall FSM,
// comparator forwarding selects, taken/stall counters.
// Ports: clk, rst_n; id_valid, id_is_beq, id_is_bne, id_rs, id_rt;
//   ex_regwrite, ex_memread, ex_rd; mem_regwrite, mem_memread, mem_rd;
//   is_equal; out fwd_a_sel, fwd_b_sel, stall, pc_src, if_flush,
//   taken_cnt, stall_cnt.
module branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_is_beq,
  input  logic        id_is_bne,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic        is_equal,
  output logic        fwd_a_sel,
  output logic        fwd_b_sel,
  output logic        stall,
  output logic        pc_src,
  output logic        if_flush,
  output logic [15:0] taken_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic       br;
  logic       taken;
  logic [1:0] need_rs, need_rt, n;
  logic       stall_c, res_c;

  // Stall cycles needed before a source register is readable.
  function automatic logic [1:0] need(input logic [4:0] r);
    logic [1:0] v;
    v = 2'd0;
    if (r != 5'd0) begin
      if (ex_regwrite && ex_memread && ex_rd == r)
        v = 2'd2;
      else if (ex_regwrite && ex_rd == r)
        v = 2'd1;
      else if (mem_regwrite && mem_memread && mem_rd == r)
        v = 2'd1;
    end
    return v;
  endfunction

  function automatic logic fwd(input logic [4:0] r);
    return (r != 5'd0) && mem_regwrite && !mem_memread &&
           (mem_rd == r);
  endfunction

  assign br      = id_valid & (id_is_beq | id_is_bne);
  // beq wins when both decode flags are set
  assign taken   = id_is_beq ? is_equal : !is_equal;
  assign need_rs = need(id_rs);
  assign need_rt = need(id_rt);
  assign n       = (need_rs > need_rt) ? need_rs : need_rt;

  assign fwd_a_sel = fwd(id_rs);
  assign fwd_b_sel = fwd(id_rt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    res_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br) begin
          if (n == 2'd0) begin
            res_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = n - 2'd1;
            state_d = (n == 2'd2) ? STALL : RESOLVE;
          end
        end
      end
      STALL: begin
        if (!br) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
          if (cnt_d == 2'd0)
            state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (!br) begin
          state_d = IDLE;
        end else if (n != 2'd0) begin
          // hazard reappeared: stall again as from IDLE
          stall_c = 1'b1;
          cnt_d   = n - 2'd1;
          state_d = (n == 2'd2) ? STALL : RESOLVE;
        end else begin
          res_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs are held low while reset is asserted.
  assign stall    = stall_c & rst_n;
  assign pc_src   = res_c & taken & rst_n;
  assign if_flush = pc_src;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pc_src && taken_cnt_q != 16'hFFFF)
      taken_cnt_d = taken_cnt_q + 16'd1;
    if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      taken_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl.
// Inputs change 1ns after the rising edge; outputs checked 2ns later.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_is_beq, id_is_bne;
  logic [4:0]  id_rs, id_rt;
  logic        ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_regwrite, mem_memread;
  logic [4:0]  mem_rd;
  logic        is_equal;
  logic        fwd_a_sel, fwd_b_sel, stall, pc_src, if_flush;
  logic [15:0] taken_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_is_beq   (id_is_beq),
    .id_is_bne   (id_is_bne),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_regwrite(mem_regwrite),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .is_equal    (is_equal),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .pc_src      (pc_src),
    .if_flush    (if_flush),
    .taken_cnt   (taken_cnt),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_is_beq = 0; id_is_bne = 0;
    id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    is_equal = 0;
  endtask

  // beq/bne with rs=3, rt=4
  task automatic branch(input logic beq, input logic bne,
                        input logic eq);
    id_valid = 1; id_is_beq = beq; id_is_bne = bne;
    id_rs = 5'd3; id_rt = 5'd4; is_equal = eq;
  endtask

  initial begin
    clr();
    rst_n = 0;
    #3;
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_pc", {15'd0, pc_src}, 16'd0);
    chk("rst_fl", {15'd0, if_flush}, 16'd0);
    chk("rst_fwd", {14'd0, fwd_a_sel, fwd_b_sel}, 16'd0);
    chk("rst_tc", taken_cnt, 16'd0);
    chk("rst_sc", stall_cnt, 16'd0);
    tick();
    rst_n = 1;
    tick();

    // no hazard, taken beq
    branch(1, 0, 1);
    #2;
    chk("nh_stall", {15'd0, stall}, 16'd0);
    chk("nh_pc", {15'd0, pc_src}, 16'd1);
    chk("nh_fl", {15'd0, if_flush}, 16'd1);
    tick();
    clr();
    #2;
    chk("nh_tc", taken_cnt, 16'd1);
    chk("nh_pc_off", {15'd0, pc_src}, 16'd0);
    tick();

    // EX ALU hazard on rs, bne not-equal
    branch(0, 1, 0);
    ex_regwrite = 1; ex_rd = 5'd3;
    #2;
    chk("alu_stall", {15'd0, stall}, 16'd1);
    chk("alu_pc0", {15'd0, pc_src}, 16'd0);
    tick();
    ex_regwrite = 0; ex_rd = 0;
    mem_regwrite = 1; mem_rd = 5'd3;
    #2;
    chk("alu_stall2", {15'd0, stall}, 16'd0);
    chk("alu_fwda", {15'd0, fwd_a_sel}, 16'd1);
    chk("alu_fwdb", {15'd0, fwd_b_sel}, 16'd0);
    chk("alu_pc", {15'd0, pc_src}, 16'd1);
    chk("alu_sc", stall_cnt, 16'd1);
    tick();
    clr();
    #2;
    chk("alu_tc", taken_cnt, 16'd2);
    tick();

    // EX load hazard on rt
    branch(1, 0, 1);
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd4;
    #2;
    chk("ld_st1", {15'd0, stall}, 16'd1);
    tick();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd4;
    #2;
    chk("ld_st2", {15'd0, stall}, 16'd1);
    chk("ld_pc2", {15'd0, pc_src}, 16'd0);
    tick();
    mem_memread = 0;
    #2;
    chk("ld_st3", {15'd0, stall}, 16'd0);
    chk("ld_pc3", {15'd0, pc_src}, 16'd1);
    chk("ld_fwdb", {15'd0, fwd_b_sel}, 16'd1);
    chk("ld_sc", stall_cnt, 16'd3);
    tick();
    clr();
    #2;
    chk("ld_tc", taken_cnt, 16'd3);
    tick();

    // $0 never hazards
    id_valid = 1; id_is_beq = 1; id_rs = 0; id_rt = 5'd5;
    is_equal = 1; ex_regwrite = 1; ex_rd = 0;
    #2;
    chk("z_stall", {15'd0, stall}, 16'd0);
    chk("z_pc", {15'd0, pc_src}, 16'd1);
    tick();
    clr();
    // both flags: beq semantics
    branch(1, 1, 0);
    #2;
    chk("pri_ne", {15'd0, pc_src}, 16'd0);
    is_equal = 1;
    #2;
    chk("pri_eq", {15'd0, pc_src}, 16'd1);
    tick();
    clr();
    #2;
    chk("pri_tc", taken_cnt, 16'd5);

    // abort: id_valid drops in STALL
    branch(1, 0, 1);
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
    #2;
    chk("ab_st1", {15'd0, stall}, 16'd1);
    tick();
    id_valid = 0;
    #2;
    chk("ab_stall", {15'd0, stall}, 16'd0);
    chk("ab_pc", {15'd0, pc_src}, 16'd0);
    chk("ab_sc", stall_cnt, 16'd4);
    tick();
    clr();
    branch(1, 0, 1);
    #2;
    chk("ab_idle_pc", {15'd0, pc_src}, 16'd1);
    chk("ab_idle_st", {15'd0, stall}, 16'd0);
    tick();
    clr();
    #2;
    chk("ab_tc", taken_cnt, 16'd6);

    // reset mid-STALL
    branch(1, 0, 1);
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd4;
    tick();
    rst_n = 0;
    #1;
    chk("rs_stall", {15'd0, stall}, 16'd0);
    chk("rs_pc", {15'd0, pc_src}, 16'd0);
    chk("rs_tc", taken_cnt, 16'd0);
    chk("rs_sc", stall_cnt, 16'd0);
    tick();
    rst_n = 1;
    #1;
    chk("rs_reeval", {15'd0, stall}, 16'd1);
    tick();
    id_valid = 0;
    tick();
    clr();
    #1;
    chk("rs_sc2", stall_cnt, 16'd1);
    chk("rs_tc2", taken_cnt, 16'd0);

    // saturation of taken_cnt
    branch(1, 0, 1);
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    chk("sat_full", taken_cnt, 16'hFFFF);
    tick();
    tick();
    chk("sat_hold", taken_cnt, 16'hFFFF);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
